// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU control path:
//                operand-forwarding select encoding and scoreboard slot type.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Width of the register address held in each scoreboard slot
    localparam int SB_ADDR_W = 4;

    // Register index that aliases the program counter
    localparam int PC_REG = 15;

    // Operand source select driven to the datapath operand muxes
    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_ALU     = 2'b01,
        FWD_PC_ZERO = 2'b11
    } fwd_sel_t;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [SB_ADDR_W-1:0] addr;
        logic                 load;
    } sb_entry_t;

    // True when a slot holds a live register write to the given address
    function automatic logic slot_writes(input sb_entry_t e,
                                         input logic [SB_ADDR_W-1:0] src);
        return e.valid & e.wen & (e.addr == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_hazard_unit_operand_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : operand_resolve
//  Description : Resolves one decode-stage source operand against the EX,
//                MEM and WB scoreboard slots: chooses the operand select and
//                flags a hazard when the value is not yet obtainable.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_resolve
    import cpu_pkg::*;
#(
    parameter int       PC_IDX   = PC_REG,
    parameter fwd_sel_t PC_SEL   = FWD_PC_ZERO,
    parameter fwd_sel_t IDLE_SEL = FWD_REG
) (
    input  logic [SB_ADDR_W-1:0] src,
    input  logic                 use_src,
    input  sb_entry_t            ex_slot,
    input  sb_entry_t            mem_slot,
    input  sb_entry_t            wb_slot,
    output logic [1:0]           sel,
    output logic                 hazard
);

    localparam logic [SB_ADDR_W-1:0] PC_ADDR = SB_ADDR_W'(PC_IDX);

    logic w_is_pc;
    logic w_ex_hit;
    logic w_older_hit;
    logic w_unused_load;

    // Only the EX slot can forward, so older slots' load flags carry no meaning here
    assign w_unused_load = mem_slot.load ^ wb_slot.load;

    assign w_is_pc     = (src == PC_ADDR);
    assign w_ex_hit    = slot_writes(ex_slot, src);
    assign w_older_hit = slot_writes(mem_slot, src) | slot_writes(wb_slot, src);

    // Priority EX > MEM > WB; a WB hit still stalls because the regfile commits at WB end
    always_comb begin
        sel    = IDLE_SEL;
        hazard = 1'b0;
        if (use_src) begin
            if (w_is_pc) begin
                sel = PC_SEL;
            end else if (w_ex_hit) begin
                if (ex_slot.load) begin
                    hazard = 1'b1;
                    sel    = FWD_REG;
                end else begin
                    sel    = FWD_ALU;
                end
            end else if (w_older_hit) begin
                hazard = 1'b1;
                sel    = FWD_REG;
            end else begin
                sel    = FWD_REG;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forward_hazard_unit
//  Description : Tracks in-flight register writes in EX/MEM/WB slots and
//                produces operand-forwarding selects, operand enables, the
//                decode stall and a saturating stall-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module forward_hazard_unit #(
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [ADDR_W-1:0] A_addr_d,
    input  logic [ADDR_W-1:0] B_addr_d,
    input  logic [ADDR_W-1:0] shift_addr_d,
    input  logic              use_A,
    input  logic              use_B,
    input  logic              use_shift,
    input  logic              wb_en_d,
    input  logic [ADDR_W-1:0] wb_addr_d,
    input  logic              is_load_d,
    input  logic              flush,
    output logic [1:0]        sel_A_in,
    output logic [1:0]        sel_B_in,
    output logic [1:0]        sel_shift_in,
    output logic              en_A,
    output logic              en_B,
    output logic              en_S,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    import cpu_pkg::*;

    sb_entry_t        r_ex;
    sb_entry_t        r_mem;
    sb_entry_t        r_wb;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [1:0] w_sel_s;
    logic       w_haz_a;
    logic       w_haz_b;
    logic       w_haz_s;
    logic       w_live;
    logic       w_issue;
    sb_entry_t  w_entry;

    operand_resolve #(
        .PC_IDX   (PC_REG),
        .PC_SEL   (FWD_PC_ZERO),
        .IDLE_SEL (FWD_REG)
    ) u_res_a (
        .src      (A_addr_d),
        .use_src  (use_A),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .wb_slot  (r_wb),
        .sel      (w_sel_a),
        .hazard   (w_haz_a)
    );

    operand_resolve #(
        .PC_IDX   (PC_REG),
        .PC_SEL   (FWD_REG),
        .IDLE_SEL (FWD_REG)
    ) u_res_b (
        .src      (B_addr_d),
        .use_src  (use_B),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .wb_slot  (r_wb),
        .sel      (w_sel_b),
        .hazard   (w_haz_b)
    );

    // An unused shift operand selects the zero path
    operand_resolve #(
        .PC_IDX   (PC_REG),
        .PC_SEL   (FWD_REG),
        .IDLE_SEL (FWD_PC_ZERO)
    ) u_res_s (
        .src      (shift_addr_d),
        .use_src  (use_shift),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .wb_slot  (r_wb),
        .sel      (w_sel_s),
        .hazard   (w_haz_s)
    );

    // Reset masks everything so stale slots cannot raise a stall while rst_n is low
    assign w_live      = rst_n & valid_d & ~flush;
    assign stall       = w_live & (w_haz_a | w_haz_b | w_haz_s);
    assign w_issue     = w_live & ~(w_haz_a | w_haz_b | w_haz_s);
    assign en_A        = w_issue & use_A;
    assign en_B        = w_issue & use_B;
    assign en_S        = w_issue & use_shift;
    assign stall_count = rst_n ? r_cnt : '0;

    assign w_entry = '{valid: 1'b1, wen: wb_en_d, addr: wb_addr_d, load: is_load_d};

    // Stall and reset park the operand muxes on the regfile (shift on zero when idle)
    always_comb begin
        sel_A_in     = w_sel_a;
        sel_B_in     = w_sel_b;
        sel_shift_in = w_sel_s;
        if (!rst_n || stall) begin
            sel_A_in     = FWD_REG;
            sel_B_in     = FWD_REG;
            sel_shift_in = (!rst_n || !use_shift) ? FWD_PC_ZERO : FWD_REG;
        end
    end

    // Slot pipeline: issued instruction enters EX, stalls and flushes insert bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_issue ? w_entry : '0;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forward_hazard_unit
//  Description : Self-checking bench for forward_hazard_unit. Directed
//                scenarios plus randomized decode traffic checked against an
//                instruction-history reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_forward_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, valid_d, use_A, use_B, use_shift, wb_en_d, is_load_d, flush;
    logic [3:0] A_addr_d, B_addr_d, shift_addr_d, wb_addr_d;
    logic [1:0] sel_A_in, sel_B_in, sel_shift_in;
    logic       en_A, en_B, en_S, stall;
    logic [15:0] stall_count;
    logic [1:0] s2_sel_a, s2_sel_b, s2_sel_s;
    logic       s2_en_a, s2_en_b, s2_en_s, s2_stall;
    logic [1:0] s2_count;

    int total = 0;
    int bad   = 0;

    forward_hazard_unit #(.ADDR_W(4), .PC_REG(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
        .A_addr_d(A_addr_d), .B_addr_d(B_addr_d), .shift_addr_d(shift_addr_d),
        .use_A(use_A), .use_B(use_B), .use_shift(use_shift),
        .wb_en_d(wb_en_d), .wb_addr_d(wb_addr_d), .is_load_d(is_load_d), .flush(flush),
        .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .stall(stall), .stall_count(stall_count)
    );

    forward_hazard_unit #(.ADDR_W(4), .PC_REG(15), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
        .A_addr_d(A_addr_d), .B_addr_d(B_addr_d), .shift_addr_d(shift_addr_d),
        .use_A(use_A), .use_B(use_B), .use_shift(use_shift),
        .wb_en_d(wb_en_d), .wb_addr_d(wb_addr_d), .is_load_d(is_load_d), .flush(flush),
        .sel_A_in(s2_sel_a), .sel_B_in(s2_sel_b), .sel_shift_in(s2_sel_s),
        .en_A(s2_en_a), .en_B(s2_en_b), .en_S(s2_en_s), .stall(s2_stall), .stall_count(s2_count)
    );

    // ------------------------------------------------------------------
    // Reference model: list of issued instructions, most recent first.
    // A source is resolved by the youngest of the last three issues that
    // writes it; only the one issued last cycle (non-load) can forward.
    // ------------------------------------------------------------------
    typedef struct {
        bit valid;
        bit wen;
        int addr;
        bit load;
    } instr_t;

    instr_t      hist[$];
    int unsigned mcount = 0;
    logic [1:0]  e_sel_a, e_sel_b, e_sel_s;
    logic        e_en_a, e_en_b, e_en_s, e_stall, e_issue;
    logic [15:0] e_count;
    logic [1:0]  e_count2;

    function automatic void src_eval(input int s, input bit used, input bit is_a,
                                     input bit is_shift, output logic [1:0] sel,
                                     output bit hz);
        sel = 2'b00;
        hz  = 1'b0;
        if (!used) begin
            sel = is_shift ? 2'b11 : 2'b00;
            return;
        end
        if (s == 15) begin
            sel = is_a ? 2'b11 : 2'b00;
            return;
        end
        for (int k = 0; k < hist.size() && k < 3; k++) begin
            if (hist[k].valid && hist[k].wen && hist[k].addr == s) begin
                if (k == 0 && !hist[k].load) sel = 2'b01;
                else                         hz  = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void model_eval();
        bit ha, hb, hs, live;
        src_eval(int'(A_addr_d), use_A, 1'b1, 1'b0, e_sel_a, ha);
        src_eval(int'(B_addr_d), use_B, 1'b0, 1'b0, e_sel_b, hb);
        src_eval(int'(shift_addr_d), use_shift, 1'b0, 1'b1, e_sel_s, hs);
        live    = rst_n && valid_d && !flush;
        e_stall = live && (ha || hb || hs);
        e_issue = live && !e_stall;
        e_en_a  = e_issue && use_A;
        e_en_b  = e_issue && use_B;
        e_en_s  = e_issue && use_shift;
        if (!rst_n || e_stall) begin
            e_sel_a = 2'b00;
            e_sel_b = 2'b00;
            e_sel_s = (!rst_n || !use_shift) ? 2'b11 : 2'b00;
        end
        e_count  = rst_n ? 16'(mcount) : 16'd0;
        e_count2 = rst_n ? ((mcount > 3) ? 2'd3 : 2'(mcount)) : 2'd0;
    endfunction

    // Advance one clock and let the model record what entered the pipe
    task automatic tick();
        instr_t ni;
        model_eval();
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
            ni = '{valid: 1'b0, wen: 1'b0, addr: 0, load: 1'b0};
            repeat (3) hist.push_back(ni);
            mcount = 0;
        end else begin
            if (e_stall && mcount < 65535) mcount++;
            ni = '{valid: e_issue, wen: e_issue && wb_en_d,
                   addr: int'(wb_addr_d), load: e_issue && is_load_d};
            hist.push_front(ni);
            while (hist.size() > 3) void'(hist.pop_back());
        end
        #1;
    endtask

    // Move to the sampling point (falling edge) and refresh model outputs
    task automatic look();
        @(negedge clk);
        model_eval();
    endtask

    task automatic set_instr(input bit v, input int a, input int b, input int s,
                             input bit ua, input bit ub, input bit us,
                             input bit wen, input int wa, input bit ld, input bit fl);
        valid_d      = v;
        A_addr_d     = 4'(a);
        B_addr_d     = 4'(b);
        shift_addr_d = 4'(s);
        use_A        = ua;
        use_B        = ub;
        use_shift    = us;
        wb_en_d      = wen;
        wb_addr_d    = 4'(wa);
        is_load_d    = ld;
        flush        = fl;
    endtask

    task automatic idle(input int n);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_instr(1, 1, 2, 3, 1, 1, 1, 1, 1, 1, 0);
        look();
        total++;
        if ({sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, stall_count} !==
            {2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset_outputs got=%b %b %b %b%b%b %b %0d", sel_A_in, sel_B_in,
                     sel_shift_in, en_A, en_B, en_S, stall, stall_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        set_instr(1, 1, 2, 0, 1, 1, 0, 1, 3, 0, 0);
        look();
        total++;
        if ({stall, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, stall_count} !==
            {1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 16'd0}) begin
            bad++;
            $display("FAIL first_after_reset got stall=%b selA=%b selB=%b selS=%b enA=%b enB=%b cnt=%0d",
                     stall, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, stall_count);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        idle(3);
        set_instr(1, 2, 3, 0, 1, 1, 0, 1, 1, 0, 0);   // ADD r1,r2,r3
        tick();
        set_instr(1, 1, 3, 0, 1, 1, 0, 1, 2, 0, 0);   // SUB r2,r1,r3
        look();
        total++;
        if ({sel_A_in, stall, en_A, sel_B_in, en_B} !== {2'b01, 1'b0, 1'b1, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL alu_forward got selA=%b stall=%b enA=%b selB=%b enB=%b exp 01 0 1 00 1",
                     sel_A_in, stall, en_A, sel_B_in, en_B);
        end
        tick();
    endtask

    task automatic test_load_use();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        set_instr(1, 0, 0, 0, 1, 0, 0, 1, 4, 1, 0);   // LDR r4,[r0]
        tick();
        set_instr(1, 4, 4, 0, 1, 1, 0, 1, 5, 0, 0);   // ADD r5,r4,r4
        for (int i = 0; i < 3; i++) begin
            look();
            total++;
            if ({stall, en_A, en_B, sel_A_in, sel_B_in} !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00}) begin
                bad++;
                $display("FAIL load_use_stall[%0d] got stall=%b enA=%b enB=%b selA=%b selB=%b",
                         i, stall, en_A, en_B, sel_A_in, sel_B_in);
            end
            tick();
        end
        look();
        total++;
        if ({stall, sel_A_in, sel_B_in, en_A, en_B} !== {1'b0, 2'b00, 2'b00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL load_use_release got stall=%b selA=%b selB=%b enA=%b enB=%b",
                     stall, sel_A_in, sel_B_in, en_A, en_B);
        end
        tick();
        idle(1);
        look();
        total++;
        if (stall_count !== 16'd3) begin
            bad++;
            $display("FAIL load_use_count got=%0d exp=3", stall_count);
        end
    endtask

    task automatic test_shift_mem();
        set_instr(1, 1, 0, 0, 1, 0, 0, 1, 6, 0, 0);   // producer r6
        tick();
        set_instr(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // unrelated, no write
        tick();
        set_instr(1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0);   // consumer via shift r6
        for (int i = 0; i < 2; i++) begin
            look();
            total++;
            if ({stall, en_S, sel_shift_in} !== {1'b1, 1'b0, 2'b00}) begin
                bad++;
                $display("FAIL shift_mem_stall[%0d] got stall=%b enS=%b selS=%b",
                         i, stall, en_S, sel_shift_in);
            end
            tick();
        end
        look();
        total++;
        if ({stall, en_S, sel_shift_in} !== {1'b0, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL shift_mem_release got stall=%b enS=%b selS=%b", stall, en_S, sel_shift_in);
        end
        tick();
        idle(1);
        look();
        total++;
        if ({stall_count, s2_count} !== {16'd5, 2'd3}) begin
            bad++;
            $display("FAIL count_saturate got cnt16=%0d cnt2=%0d exp 5 3", stall_count, s2_count);
        end
    endtask

    task automatic test_pc_reg();
        idle(3);
        set_instr(1, 0, 0, 0, 1, 0, 0, 1, 15, 0, 0);  // writer of r15
        tick();
        set_instr(1, 15, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // reader A=r15, no shift
        look();
        total++;
        if ({stall, sel_A_in, sel_shift_in, en_A} !== {1'b0, 2'b11, 2'b11, 1'b1}) begin
            bad++;
            $display("FAIL pc_reg got stall=%b selA=%b selS=%b enA=%b exp 0 11 11 1",
                     stall, sel_A_in, sel_shift_in, en_A);
        end
        tick();
    endtask

    task automatic test_flush();
        idle(3);
        set_instr(1, 0, 0, 0, 1, 0, 0, 1, 7, 1, 0);   // LDR r7
        tick();
        set_instr(1, 7, 1, 2, 1, 1, 1, 1, 8, 0, 1);   // dependent, flushed
        look();
        total++;
        if ({stall, en_A, en_B, en_S} !== 4'b0000) begin
            bad++;
            $display("FAIL flush_kill got stall=%b enA=%b enB=%b enS=%b", stall, en_A, en_B, en_S);
        end
        tick();
        set_instr(1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // reads flushed dest r8
        look();
        total++;
        if ({stall, sel_A_in, en_A} !== {1'b0, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL flush_bubble got stall=%b selA=%b enA=%b exp 0 00 1", stall, sel_A_in, en_A);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        set_instr(1, 0, 0, 0, 1, 0, 0, 1, 4, 1, 0);
        tick();
        set_instr(1, 4, 0, 0, 1, 0, 0, 1, 5, 0, 0);
        look();
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mid_stall_pre got stall=%b exp=1", stall);
        end
        tick();
        rst_n = 1'b0;
        look();
        total++;
        if ({stall, en_A, sel_A_in, sel_shift_in, stall_count} !== {1'b0, 1'b0, 2'b00, 2'b11, 16'd0}) begin
            bad++;
            $display("FAIL mid_stall_in_reset got stall=%b enA=%b selA=%b selS=%b cnt=%0d",
                     stall, en_A, sel_A_in, sel_shift_in, stall_count);
        end
        tick();
        rst_n = 1'b1;
        look();
        total++;
        if ({stall, stall_count, en_A} !== {1'b0, 16'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_stall_after got stall=%b cnt=%0d enA=%b", stall, stall_count, en_A);
        end
        tick();
    endtask

    function automatic int rnd_addr();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 15 : r;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_instr(($urandom_range(0, 7) != 0), rnd_addr(), rnd_addr(), rnd_addr(),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rnd_addr(),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            look();
            total++;
            if ({sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, stall_count, s2_count} !==
                {e_sel_a, e_sel_b, e_sel_s, e_en_a, e_en_b, e_en_s, e_stall, e_count, e_count2}) begin
                bad++;
                $display("FAIL random[%0d] got sel=%b/%b/%b en=%b%b%b st=%b cnt=%0d/%0d exp sel=%b/%b/%b en=%b%b%b st=%b cnt=%0d/%0d",
                         i, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, stall_count, s2_count,
                         e_sel_a, e_sel_b, e_sel_s, e_en_a, e_en_b, e_en_s, e_stall, e_count, e_count2);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_forward();
        test_load_use();
        test_shift_mem();
        test_pc_reg();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Control-side counterpart to the CPU datapath: produces the operand-forwarding selects, operand-register enables and pipeline stall that the datapath consumes.
- Tracks in-flight register writes across the EX, MEM and WB slots.
- Decides per decode-stage source operand whether to read the regfile, forward ALU_out, substitute PC/zero, or stall.
- Sits between the decoder and the datapath.

Parameters:
ADDR_W, 4, register address width
PC_REG, 15, register index treated as PC (never a hazard; selects PC path)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
valid_d  in  1  decode stage holds a real instruction
A_addr_d  in  ADDR_W  source A register
B_addr_d  in  ADDR_W  source B register
shift_addr_d  in  ADDR_W  register-specified shift amount source
use_A  in  1  instruction reads A
use_B  in  1  instruction reads B
use_shift  in  1  instruction reads shift register
wb_en_d  in  1  instruction writes a register
wb_addr_d  in  ADDR_W  destination register
is_load_d  in  1  destination is written from memory, not the ALU
flush  in  1  branch taken: kill the decode instruction
sel_A_in  out  2  00 regfile, 01 ALU_out, 11 PC
sel_B_in  out  2  00 regfile, 01 ALU_out
sel_shift_in  out  2  00 regfile, 01 ALU_out, 11 zero
en_A, en_B, en_S  out  1 each  operand register load enables
stall  out  1  hold fetch/decode this cycle
stall_count  out  CNT_W  total stall cycles, saturating

Behaviour:
- Scoreboard: three registered slots EX, MEM, WB. Each slot holds {valid, wen, addr, load}.
- Every posedge: WB<=MEM and MEM<=EX.
  - EX <= decode info (valid_d & ~stall & ~flush); otherwise EX <= bubble (all zero).
- Source match in slot X, for each used source s: X.valid & X.wen & X.addr==s & s!=PC_REG.
- Per source, priority EX > MEM > WB:
  - EX match & ~EX.load: select 01 (forward ALU_out), no stall.
  - EX match & EX.load: hazard.
  - MEM or WB match (no EX match): hazard. Regfile writes commit at the end of WB, so a WB match still stalls.
  - No match: select 00.
  - A source equal to PC_REG: sel_A_in=11. For B and shift, PC_REG uses 00.
- Unused sources:
  - sel_*=00.
  - Exception: sel_shift_in=11 (zero) when use_shift=0.
- stall = valid_d & ~flush & (any used source hazard).
- Enables:
  - en_A = valid_d & ~stall & ~flush & use_A; same form for en_B/use_B and en_S/use_shift.
  - While stalled, all enables are 0 and all selects are 00, except sel_shift_in as above.
- Outputs are combinational from decode inputs and registered slots (Mealy). There is no added latency.
- Load-use from the EX slot: stalls 3 cycles (EX, MEM, WB), then the consumer reads 00 on the 4th cycle.
- ALU producer two instructions ahead (in MEM): stalls 2 cycles.
- flush has priority over stall: stall=0, enables=0, bubble inserted.
- stall_count increments by 1 on every cycle stall=1 and saturates at all-ones (no wrap).
- Reset, including mid-stall: all slots invalid, stall_count=0, and therefore stall=0.
  - During reset all outputs are 0, except sel_shift_in=11.
  - The first post-reset cycle sees no hazards.
- A destination equal to the instruction's own source does not self-match; only older slots are compared.

Decomposition:
- Shared package cpu_pkg:
  - enum fwd_sel_t {FWD_REG=2'b00, FWD_ALU=2'b01, FWD_PC_ZERO=2'b11}.
  - struct sb_entry_t {valid, wen, addr, load}.
  - Constant PC_REG.
- One natural sub-module: operand_resolve.
  - Combinational, instantiated three times (A, B, shift).
  - Inputs: source, use flag, three slots. Outputs: sel, hazard.
- Top level holds the slot pipeline, stall/flush logic and counter.

Test Plan:
- ADD r1 then SUB r2,r1,r3 back to back -> second cycle sel_A_in=01, stall=0, en_A=1.
- LDR r4 then ADD r5,r4,r4 -> stall=1 for 3 cycles, then sel_A_in=sel_B_in=00, en_A=en_B=1; stall_count=3.
- Producer r6, one unrelated instruction, then consumer of r6 via shift_addr -> consumer stalls 2 cycles, en_S=0 during the stall, then sel_shift_in=00.
- Writer of r15, then reader A=r15 -> no stall, sel_A_in=11; use_shift=0 gives sel_shift_in=11.
- Hazard present with flush=1 -> stall=0, all enables 0, next EX slot is a bubble (a following dependent instruction shows no match).
- rst_n=0 asserted mid load-use stall -> next cycle stall=0 and stall_count=0. Also with CNT_W=2, 5 stall cycles -> stall_count holds at 3.
